// File: rtl/clock_24h.sv
// rtl/clock_24h.sv - 24-hour BCD time-of-day keeper with 1 Hz prescaler, key setting and hour chime
module clock_24h #(
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic        mode_set,
    input  logic        hour_set_pre,
    input  logic        min_set_pre,
    output logic [31:0] cnt_24,
    output logic        sec_tick,
    output logic        hour_chime
);

    localparam int PRE_W = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_FREQ - 1);

    logic [PRE_W-1:0] pre, pre_nxt;
    logic [7:0]       hours, minutes, seconds;
    logic [7:0]       hours_nxt, minutes_nxt, seconds_nxt;
    logic             tick_nxt, chime_nxt;

    // Two-digit BCD increment wrapping 23 -> 00.
    function automatic logic [7:0] hour_inc(input logic [7:0] h);
        if (h == 8'h23)
            return 8'h00;
        if (h[3:0] == 4'd9)
            return {h[7:4] + 4'd1, 4'd0};
        return {h[7:4], h[3:0] + 4'd1};
    endfunction

    // Two-digit BCD increment wrapping 59 -> 00 (minutes and seconds).
    function automatic logic [7:0] base60_inc(input logic [7:0] v);
        if (v == 8'h59)
            return 8'h00;
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    always_comb begin
        pre_nxt     = pre;
        hours_nxt   = hours;
        minutes_nxt = minutes;
        seconds_nxt = seconds;
        tick_nxt    = 1'b0;
        chime_nxt   = 1'b0;
        if (mode_set) begin
            // Set mode freezes the prescaler so the next run starts a full second.
            pre_nxt = '0;
            if (hour_set_pre)
                hours_nxt = hour_inc(hours);
            if (min_set_pre) begin
                minutes_nxt = base60_inc(minutes);
                seconds_nxt = 8'h00;
            end
        end else if (pre == PRE_MAX) begin
            pre_nxt     = '0;
            tick_nxt    = 1'b1;
            seconds_nxt = base60_inc(seconds);
            if (seconds == 8'h59) begin
                minutes_nxt = base60_inc(minutes);
                if (minutes == 8'h59) begin
                    hours_nxt = hour_inc(hours);
                    chime_nxt = 1'b1;
                end
            end
        end else begin
            pre_nxt = pre + PRE_W'(1);
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            pre        <= '0;
            hours      <= 8'h00;
            minutes    <= 8'h00;
            seconds    <= 8'h00;
            sec_tick   <= 1'b0;
            hour_chime <= 1'b0;
        end else begin
            pre        <= pre_nxt;
            hours      <= hours_nxt;
            minutes    <= minutes_nxt;
            seconds    <= seconds_nxt;
            sec_tick   <= tick_nxt;
            hour_chime <= chime_nxt;
        end
    end

    // Separator nibbles are the display dash glyph.
    assign cnt_24 = {hours, 4'hA, minutes, 4'hA, seconds};

endmodule

// File: tb/tb_clock_24h.sv
// tb/tb_clock_24h.sv - randomized self-checking bench for clock_24h against a seconds-of-day model
module tb_clock_24h;

    logic        sys_clk;
    logic        rst_n;
    logic        mode_set;
    logic        hour_set_pre;
    logic        min_set_pre;
    logic [31:0] cnt_24;
    logic        sec_tick;
    logic        hour_chime;

    int n_checks = 0;
    int n_errors = 0;

    int hh, mm, ss, m_pre, tod;
    logic exp_tick, exp_chime;

    clock_24h #(.CLK_FREQ(10)) dut (
        .sys_clk      (sys_clk),
        .rst_n        (rst_n),
        .mode_set     (mode_set),
        .hour_set_pre (hour_set_pre),
        .min_set_pre  (min_set_pre),
        .cnt_24       (cnt_24),
        .sec_tick     (sec_tick),
        .hour_chime   (hour_chime)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack(input int h, input int m, input int s);
        return {4'(h / 10), 4'(h % 10), 4'hA, 4'(m / 10), 4'(m % 10), 4'hA, 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic model_reset();
        hh = 0; mm = 0; ss = 0; m_pre = 0;
        exp_tick = 1'b0; exp_chime = 1'b0;
    endtask

    task automatic step(input logic md, input logic hs, input logic ms);
        @(negedge sys_clk);
        mode_set = md; hour_set_pre = hs; min_set_pre = ms;
        exp_tick = 1'b0; exp_chime = 1'b0;
        if (!rst_n) begin
            model_reset();
        end else if (md) begin
            m_pre = 0;
            if (hs) hh = (hh + 1) % 24;
            if (ms) begin mm = (mm + 1) % 60; ss = 0; end
        end else if (m_pre == 9) begin
            m_pre = 0;
            tod = (hh * 3600 + mm * 60 + ss + 1) % 86400;
            hh = tod / 3600; mm = (tod / 60) % 60; ss = tod % 60;
            exp_tick = 1'b1;
            exp_chime = (tod % 3600 == 0);
        end else begin
            m_pre++;
        end
        @(posedge sys_clk);
        #1;
        check("cnt_24", cnt_24, pack(hh, mm, ss));
        check("sec_tick", 32'(sec_tick), 32'(exp_tick));
        check("hour_chime", 32'(hour_chime), 32'(exp_chime));
    endtask

    task automatic set_time(input int h, input int m);
        step(1'b1, 1'b0, 1'b0);
        while (hh != h) step(1'b1, 1'b1, 1'b0);
        while (mm != m) step(1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0; mode_set = 1'b0; hour_set_pre = 1'b0; min_set_pre = 1'b0;
        model_reset();
        #12;
        check("reset_cnt", cnt_24, 32'h00A00A00);
        check("reset_tick", 32'(sec_tick), 32'd0);
        check("reset_chime", 32'(hour_chime), 32'd0);
        step(1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // First tick after 10 run cycles; per-cycle checks cover the quiet 9.
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0);
        check("first_tick_cnt", cnt_24, 32'h00A00A01);
        check("first_tick_pulse", 32'(sec_tick), 32'd1);
        step(1'b0, 1'b0, 1'b0);
        check("tick_one_cycle", 32'(sec_tick), 32'd0);

        // 12:59:xx -> 13:00:00
        set_time(12, 59);
        for (int i = 0; i < 600; i++) step(1'b0, 1'b0, 1'b0);
        check("hour_carry_cnt", cnt_24, 32'h13A00A00);
        check("hour_carry_chime", 32'(hour_chime), 32'd1);

        // 23:59:xx -> 00:00:00
        set_time(23, 59);
        for (int i = 0; i < 600; i++) step(1'b0, 1'b0, 1'b0);
        check("day_wrap_cnt", cnt_24, 32'h00A00A00);
        check("day_wrap_chime", 32'(hour_chime), 32'd1);

        // Set mode from 00:00:37
        for (int i = 0; i < 370; i++) step(1'b0, 1'b0, 1'b0);
        check("at_37", cnt_24, 32'h00A00A37);
        step(1'b1, 1'b0, 1'b1);
        check("min_set_clears_sec", cnt_24, 32'h00A01A00);
        for (int i = 0; i < 24; i++) step(1'b1, 1'b1, 1'b0);
        check("hour_24_pulses", cnt_24, 32'h00A01A00);
        while (mm != 59) step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        check("min_wrap_no_carry", cnt_24, 32'h00A00A00);
        for (int i = 0; i < 100; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        check("both_pulses", cnt_24, 32'h01A01A00);
        step(1'b0, 1'b1, 1'b1);
        check("run_pulses_ignored", cnt_24, 32'h01A01A00);

        // Random mode stretches and pulses
        for (int blk = 0; blk < 60; blk++) begin
            logic md;
            md = ($urandom_range(0, 9) < 3);
            for (int i = 0; i < $urandom_range(5, 60); i++)
                step(md, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
        end

        // Asynchronous reset mid-count at 05:06:07, pre=7
        step(1'b0, 1'b0, 1'b0);
        set_time(5, 6);
        for (int i = 0; i < 77; i++) step(1'b0, 1'b0, 1'b0);
        check("pre_reset_cnt", cnt_24, 32'h05A06A07);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_cnt", cnt_24, 32'h00A00A00);
        check("async_reset_tick", 32'(sec_tick), 32'd0);
        model_reset();
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0);
        check("post_reset_tick", 32'(sec_tick), 32'd1);
        check("post_reset_cnt", cnt_24, 32'h00A00A01);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
